// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU with a
// sign-fixup cycle, and direct MTHI/MTLO writes.
module hilo_muldiv_ctrl #(
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        accept;
    logic        signed_div;
    logic        neg_quo;
    logic        neg_rem;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    assign accept     = start_i && (op_i < 3'd6);
    assign signed_div = (op_q == OpDiv);
    assign neg_quo    = signed_div && (a_q[31] ^ b_q[31]);
    assign neg_rem    = signed_div && a_q[31];

    // Sign-extending both operands to 64 bits makes the low 64 product bits exact for MULT.
    assign ext_a = (op_q == OpMult) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign ext_b = (op_q == OpMult) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign prod  = ext_a * ext_b;

    // Dividend bits shift out of quo_q into the partial remainder; borrow means restore.
    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d  = op_i;
                    a_d   = a_i;
                    b_d   = b_i;
                    cnt_d = 6'd0;
                    case (op_i)
                        OpMthi: begin
                            hi_d   = a_i;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = a_i;
                            done_d = 1'b1;
                        end
                        OpMult, OpMultu: state_d = StMul;
                        OpDiv, OpDivu: begin
                            state_d = StDiv;
                            rem_d   = 32'd0;
                            quo_d   = (op_i == OpDiv && a_i[31]) ? -a_i : a_i;
                            dvs_d   = (op_i == OpDiv && b_i[31]) ? -b_i : b_i;
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                {hi_d, lo_d} = prod;
                done_d       = 1'b1;
                state_d      = StIdle;
            end
            StDiv: begin
                cnt_d = cnt_q + 6'd1;
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 6'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (b_q == 32'd0) begin
                    lo_d = DIV_ZERO_LO;
                    hi_d = a_q;
                end else begin
                    lo_d = neg_quo ? -quo_q : quo_q;
                    hi_d = neg_rem ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            cnt_q   <= 6'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: operation-level reference model compared every cycle, plus
// directed literal checks on the corner cases.
module tb_hilo_muldiv_ctrl;

    localparam logic [31:0] DZ = 32'hFFFF_FFFF;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(
        .DIV_ZERO_LO(DZ)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .op_i   (op),
        .a_i    (a),
        .b_i    (b),
        .busy_o (busy),
        .done_o (done),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mul_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx;
        longint sy;
        longint p;
        logic [63:0] u;
        if (o == 3'd0) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p  = sx * sy;
            return 64'(p);
        end
        u = {32'b0, x} * {32'b0, y};
        return u;
    endfunction

    // Returns {hi, lo} = {remainder, quotient}.
    function automatic logic [63:0] div_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        if (y == 32'd0) return {x, DZ};
        if (o == 3'd2) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = sx / sy;
            r  = sx % sy;
            return {r[31:0], q[31:0]};
        end
        return {x % y, x / y};
    endfunction

    // Reference model: an operation completes a fixed number of edges after acceptance.
    int          m_rem;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_done;
    logic [63:0] m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_done <= 1'b0;
            m_res  <= 64'd0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end else if (start && op < 3'd6) begin
                case (op)
                    3'd4: begin
                        m_hi   <= a;
                        m_done <= 1'b1;
                    end
                    3'd5: begin
                        m_lo   <= a;
                        m_done <= 1'b1;
                    end
                    3'd0, 3'd1: begin
                        m_res <= mul_model(op, a, b);
                        m_rem <= 1;
                    end
                    default: begin
                        m_res <= div_model(op, a, b);
                        m_rem <= 33;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(m_rem != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, input bit junk);
        edges = 0;
        while (!done && edges < 40) begin
            if (junk) begin
                start = 1'($urandom_range(0, 1));
                op    = 3'($urandom_range(0, 7));
                a     = $urandom;
                b     = $urandom;
            end
            @(posedge clk);
            #2;
            edges++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d edges, required done", edges);
        end
    endtask

    initial begin
        int e;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done(e, 1'b0);
        chk("mult_edges", 32'(e), 32'd1);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        @(posedge clk);
        #2;
        chk("mult_done_pulse", 32'(done), 32'd0);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_done(e, 1'b0);
        chk("multu_hi", hi, 32'd2);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(e, 1'b0);
        chk("div_edges", 32'(e), 32'd33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(3'd3, 32'd7, 32'd2);
        wait_done(e, 1'b0);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        issue(3'd3, 32'd100, 32'd0);
        wait_done(e, 1'b0);
        chk("divz_edges", 32'(e), 32'd33);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'd100);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(e, 1'b0);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);

        // MULT request at E5 must be dropped while the divide runs.
        issue(3'd2, 32'd1000, 32'd7);
        repeat (4) @(posedge clk);
        #2;
        issue(3'd0, 32'd9, 32'd9);
        wait_done(e, 1'b0);
        chk("ign_edges", 32'(e), 32'd28);
        chk("ign_lo", lo, 32'd142);
        chk("ign_hi", hi, 32'd6);
        issue(3'd5, 32'h1234, 32'd0);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_lo", lo, 32'h1234);
        chk("b2b_hi", hi, 32'd6);

        issue(3'd6, 32'hDEAD_BEEF, 32'd1);
        chk("noop_done", 32'(done), 32'd0);
        chk("noop_busy", 32'(busy), 32'd0);
        chk("noop_lo", lo, 32'h1234);

        // Asynchronous reset between E10 and E11 of a divide.
        issue(3'd2, 32'd12345, 32'd67);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        issue(3'd1, 32'd5, 32'd6);
        wait_done(e, 1'b0);
        chk("post_rst_lo", lo, 32'd30);
        chk("post_rst_hi", hi, 32'd0);

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            issue(ro, ra, rb);
            if (ro >= 3'd6) begin
                @(posedge clk);
                #2;
            end else begin
                wait_done(e, 1'b1);
            end
        end

        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 Parameter DIV_ZERO_LO, default 32'hFFFF_FFFF, SHALL be the LO value written by any divide with b==0.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset; SHALL be asynchronous and active-high.
REQ-004 start  input  1  SHALL request an operation; sampled only on edges where busy==0.
REQ-005 op  input  3  SHALL encode the operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 SHALL be ignored as no-ops with no state change.
REQ-006 a  input  32  SHALL be operand rs (dividend / multiplicand / MTHI/MTLO source), captured at acceptance.
REQ-007 b  input  32  SHALL be operand rt (divisor / multiplier), captured at acceptance.
REQ-008 busy  output  1  SHALL be high while a MULT/DIV sequence is in progress; CPU stalls MFHI/MFLO and new requests on it.
REQ-009 done  output  1  SHALL pulse high for exactly one cycle when HI/LO have just been updated.
REQ-010 hi  output  32  SHALL be the registered HI value.
REQ-011 lo  output  32  SHALL be the registered LO value.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, FIX; busy SHALL be 1 exactly in MUL, DIV and FIX.
REQ-013 Acceptance edge E0: state IDLE and start==1 with a valid op; a, b and op SHALL be latched at E0.
REQ-014 MTHI/MTLO SHALL write hi (resp. lo) with a at E0, leave the other register unchanged, stay in IDLE, and assert done in the cycle after E0.
REQ-015 MULT/MULTU SHALL go IDLE->MUL at E0 and MUL->IDLE at E1, writing {hi,lo} with the 64-bit product at E1; done=1 and busy=0 in the cycle after E1.
REQ-016 MULT SHALL treat a, b as two's-complement signed; MULTU as unsigned; the product SHALL be the full 64 bits with no truncation.
REQ-017 DIV/DIVU SHALL go IDLE->DIV at E0, perform one restoring quotient bit per edge on E1..E32 using operand magnitudes, go DIV->FIX at E32, and FIX->IDLE at E33 writing lo=quotient, hi=remainder; done=1 in the cycle after E33.
REQ-018 An internal 6-bit iteration counter SHALL load 0 at E0, increment each DIV edge, and trigger DIV->FIX when it reaches 31 at E32.
REQ-019 DIV signed results: quotient truncated toward zero; remainder takes the sign of the dividend; negation applied in FIX only.
REQ-020 DIV with a=32'h8000_0000, b=32'hFFFF_FFFF SHALL yield lo=32'h8000_0000, hi=0.
REQ-021 Any divide with b==0 SHALL take the normal 34-edge sequence and write lo=DIV_ZERO_LO, hi=a.
REQ-022 hi/lo SHALL hold their values while busy and SHALL change only at the write edges defined in REQ-014/015/017.
REQ-023 start while busy==1 SHALL be ignored entirely (no queuing, no latch of a/b/op).
REQ-024 start in the cycle done is high SHALL be accepted normally (back-to-back operations permitted).
REQ-025 done SHALL never be asserted for ignored ops (110/111).

Reset
REQ-026 reset==1 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and abort any operation in progress with no partial HI/LO write.
REQ-027 After reset deasserts, the first rising edge with start==1 SHALL be a valid acceptance edge.

Verification
REQ-028 MULT a=32'hFFFF_FFFE (-2), b=3 -> after E1: hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, done one cycle; MULTU same operands -> hi=2, lo=32'hFFFF_FFFA.
REQ-029 DIV a=-7, b=2 -> busy for E1..E33, done after E33, lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU a=7, b=2 -> lo=3, hi=1.
REQ-030 DIVU a=100, b=0 -> after E33 lo=32'hFFFF_FFFF, hi=100; DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
REQ-031 Start DIV, assert start with MULT at E5 -> MULT ignored, DIV result unchanged; MTLO a=0x1234 in done cycle -> accepted, lo=0x1234 next cycle, hi keeps quotient remainder.
REQ-032 Assert reset asynchronously mid-DIV (between E10 and E11) -> busy, done, hi, lo go 0 before next edge; subsequent MULTU 5*6 -> lo=30, hi=0.
